// File: rtl/vga_timing_recovery.sv
// vga_timing_recovery: recovers raster geometry from a sync/blank pixel stream,
// emits visible-pixel coordinates and locks once the frame measurement repeats.
module vga_timing_recovery #(
    parameter int CNT_W       = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             hsync_n_i,
    input  logic             vsync_n_i,
    input  logic             blank_n_i,
    output logic             pixel_valid_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic [CNT_W-1:0] h_total_o,
    output logic [CNT_W-1:0] h_active_o,
    output logic [CNT_W-1:0] v_total_o,
    output logic [CNT_W-1:0] v_active_o,
    output logic             locked_o,
    output logic             frame_start_o
);

    localparam logic [CNT_W-1:0] CMAX   = '1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [3:0]       LOCK_M1 = 4'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + ONE;
    endfunction

    // previous accepted sample (edge detection) and per-line event bookkeeping
    logic             hs_q, vs_q, bl_q;
    logic             hs_seen_q, bl_seen_q;
    logic [CNT_W-1:0] pix_cnt_q, hact_cnt_q;
    logic             vis_q, full_q;
    // per-frame accumulation
    logic [CNT_W-1:0] line_cnt_q, vact_q, ht_q, ha_q;
    logic             have_ht_q, have_ha_q, err_q;
    // pixel coordinate counters and FSM
    logic [CNT_W-1:0] xcnt_q, ycnt_q;
    logic [3:0]       match_q;
    state_e           state_q;

    logic             ev_hs, ev_bl, ls, fs, close, match, pix_sat, line_sat;
    logic [CNT_W-1:0] line_len, ht_d, ha_d, vt_d, va_d, xs, ys;
    logic             err_d;
    logic [3:0]       match_inc;

    // line/frame event decode and the frame tuple as it stands after this sample
    always_comb begin
        ev_hs     = hs_q & ~hsync_n_i;
        ev_bl     = ~bl_q & blank_n_i;
        // a line starts on the first of {hsync fall, blank rise}; the other kind
        // in the same line is swallowed, the same kind again opens a new line
        ls        = valid_i & ((ev_hs & (hs_seen_q | ~bl_seen_q)) |
                               (ev_bl & (bl_seen_q | ~hs_seen_q)));
        fs        = valid_i & vs_q & ~vsync_n_i;
        close     = ls & full_q;
        line_len  = (pix_cnt_q == CMAX) ? CMAX : pix_cnt_q + ONE;
        ht_d      = ht_q;
        ha_d      = ha_q;
        err_d     = err_q;
        if (close) begin
            if (!have_ht_q)               ht_d  = line_len;
            else if (line_len != ht_q)    err_d = 1'b1;
            if (vis_q) begin
                if (!have_ha_q)           ha_d  = hact_cnt_q;
                else if (hact_cnt_q != ha_q) err_d = 1'b1;
            end
        end
        vt_d      = ls ? sat_inc(line_cnt_q) : line_cnt_q;
        va_d      = (ls & vis_q) ? sat_inc(vact_q) : vact_q;
        match     = (ht_d == h_total_o) && (ha_d == h_active_o) &&
                    (vt_d == v_total_o) && (va_d == v_active_o) && !err_d;
        match_inc = match_q + 4'd1;
        pix_sat   = valid_i & ~ls & (pix_cnt_q == CMAX - ONE);
        line_sat  = ls & ~fs & (line_cnt_q == CMAX - ONE);
        xs        = fs ? '0 : xcnt_q;
        ys        = fs ? '0 : ycnt_q;
    end

    // all state advances only on accepted samples; strobes drop otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hs_q <= 1'b1; vs_q <= 1'b1; bl_q <= 1'b0;
            hs_seen_q <= 1'b0; bl_seen_q <= 1'b0;
            pix_cnt_q <= '0; hact_cnt_q <= '0; vis_q <= 1'b0; full_q <= 1'b0;
            line_cnt_q <= '0; vact_q <= '0; ht_q <= '0; ha_q <= '0;
            have_ht_q <= 1'b0; have_ha_q <= 1'b0; err_q <= 1'b0;
            xcnt_q <= '0; ycnt_q <= '0; match_q <= '0; state_q <= SEARCH;
            pixel_valid_o <= 1'b0; frame_start_o <= 1'b0; locked_o <= 1'b0;
            x_o <= '0; y_o <= '0;
            h_total_o <= '0; h_active_o <= '0; v_total_o <= '0; v_active_o <= '0;
        end else begin
            pixel_valid_o <= 1'b0;
            frame_start_o <= 1'b0;
            if (valid_i) begin
                hs_q <= hsync_n_i;
                vs_q <= vsync_n_i;
                bl_q <= blank_n_i;
                frame_start_o <= fs;

                // line-level counters restart at every line start
                if (ls) begin
                    hs_seen_q  <= ev_hs;
                    bl_seen_q  <= ev_bl;
                    pix_cnt_q  <= '0;
                    hact_cnt_q <= blank_n_i ? ONE : '0;
                    vis_q      <= blank_n_i;
                    full_q     <= 1'b1;
                end else begin
                    hs_seen_q  <= hs_seen_q | ev_hs;
                    bl_seen_q  <= bl_seen_q | ev_bl;
                    pix_cnt_q  <= sat_inc(pix_cnt_q);
                    hact_cnt_q <= blank_n_i ? sat_inc(hact_cnt_q) : hact_cnt_q;
                    vis_q      <= vis_q | blank_n_i;
                end

                // frame accumulators: the closing line is already folded into *_d
                if (fs) begin
                    line_cnt_q <= '0; vact_q <= '0; ht_q <= '0; ha_q <= '0;
                    have_ht_q <= 1'b0; have_ha_q <= 1'b0; err_q <= 1'b0;
                    // a line already running at frame start is not a complete line
                    if (!ls) full_q <= 1'b0;
                end else begin
                    line_cnt_q <= vt_d; vact_q <= va_d;
                    ht_q <= ht_d; ha_q <= ha_d; err_q <= err_d;
                    if (close) begin
                        have_ht_q <= 1'b1;
                        if (vis_q) have_ha_q <= 1'b1;
                    end
                end

                // visible pixel coordinates, restarted at frame start
                if (blank_n_i) begin
                    pixel_valid_o <= 1'b1;
                    x_o    <= xs;
                    y_o    <= ys;
                    xcnt_q <= sat_inc(xs);
                    ycnt_q <= ys;
                end else begin
                    xcnt_q <= '0;
                    ycnt_q <= fs ? '0 : (bl_q ? sat_inc(ycnt_q) : ycnt_q);
                end

                // lock FSM; a runaway counter means the input lost its timing
                if (pix_sat || line_sat) begin
                    state_q  <= SEARCH;
                    locked_o <= 1'b0;
                    match_q  <= '0;
                end else if (fs) begin
                    case (state_q)
                        SEARCH: begin
                            state_q <= MEASURE;
                            match_q <= '0;
                        end
                        MEASURE: begin
                            if (match) begin
                                match_q <= match_inc;
                                if (match_inc >= LOCK_M1) begin
                                    state_q  <= LOCKED;
                                    locked_o <= 1'b1;
                                end
                            end else begin
                                match_q <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!match) begin
                                state_q  <= MEASURE;
                                locked_o <= 1'b0;
                                match_q  <= '0;
                            end
                        end
                        default: begin
                            state_q  <= SEARCH;
                            locked_o <= 1'b0;
                        end
                    endcase
                    if (state_q != SEARCH) begin
                        h_total_o  <= ht_d;
                        h_active_o <= ha_d;
                        v_total_o  <= vt_d;
                        v_active_o <= va_d;
                    end
                end
            end
        end
    end

endmodule
